enc_frame_sequencer: RTL and testbench
======================================

Name: enc_frame_sequencer

Overview:
- Sequences framed symbol traffic into the 8b/10b encoder.
- Arbitrates round-robin between two byte-stream sources and holds the grant for a whole frame.
- Emits the 9-bit encoder input stream {K flag, byte}: sync commas, payload, end-of-data mark, CRC-32, end-of-frame comma.
- Sits directly upstream of the encoder's pushin/startin/datain inputs.

Parameters:
SYNC_CNT, 4, number of K28.1 sync symbols per frame (the first one carries startout); legal range 1-15.
MAX_LEN, 1024, maximum payload bytes per frame; larger frames are truncated.
GAP_CYC, 2, minimum idle cycles between the K28.5 end symbol and the next frame's first sync symbol.

Ports:
clk  input  1  clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-high; clears all state immediately.
req  input  2  per-source frame request; held high until that source's last byte is accepted.
gnt  output  2  one-hot grant, registered; held from the first sync symbol until the K28.5 symbol.
src_valid  input  2  per-source byte valid.
src_data  input  16  source 0 byte on [7:0], source 1 byte on [15:8].
src_last  input  2  marks the final payload byte of the frame.
src_ready  output  2  per-source ready; a byte transfers when valid and ready are both high.
pushout  output  1  symbol valid toward the encoder.
startout  output  1  high with the first sync symbol only.
dataout  output  9  [8]=K flag, [7:0]=byte.
len_err  output  1  one-cycle pulse when a frame is truncated at MAX_LEN.

Behaviour:
- Reset values: gnt=0, src_ready=0, pushout=0, startout=0, dataout=0, len_err=0.
- Reset also sets the round-robin pointer to favour source 0, CRC=FFFFFFFF, and state=IDLE.
- All outputs except src_ready are registered. src_ready is decoded from registered state and gnt only.
- IDLE:
  - If any req bit is high, grant the favoured requester, else the other one.
  - At that clock edge: gnt is set, state goes to SYNC, and the first sync symbol is registered (pushout=1, startout=1, dataout=9'h13C).
  - The pointer toggles to favour the non-granted source.
- SYNC: emit 9'h13C with startout=0 until SYNC_CNT symbols total have been sent, then go to DATA.
- DATA:
  - src_ready[g]=1.
  - On each transfer, emit {0,byte} the next cycle and fold the byte into the CRC.
  - If src_valid[g]=0, emit nothing that cycle (pushout=0). Bubbles do not affect the CRC.
  - On a transfer with src_last, go to EOD.
  - On the MAX_LEN-th byte without src_last, go to DRAIN and pulse len_err.
- DRAIN: src_ready[g]=1, bytes are discarded with no output, and the CRC is frozen. On src_last, go to EOD.
- EOD: emit K23.7 (9'h1F7) and go to CRC.
- CRC:
  - CRC-32 IEEE, reflected, poly 04C11DB7, init FFFFFFFF, final XOR FFFFFFFF.
  - Emit 4 bytes, least-significant byte first, K flag=0, one per cycle; then go to EOF.
- EOF: emit K28.5 (9'h1BC), clear gnt, reset CRC to FFFFFFFF, and go to GAP.
- GAP: pushout=0 for GAP_CYC cycles, then go to IDLE. With GAP_CYC=0, go straight to IDLE.
- Payload byte count: 11-bit counter, cleared in IDLE; no wrap is possible below MAX_LEN.
- req edge cases:
  - req on a non-granted source during a frame is ignored until IDLE.
  - req deasserting mid-frame has no effect; the frame is ended only by src_last.
- Async reset mid-frame: the frame is abandoned and no end symbols are sent. The next frame starts cleanly with startout.
- Non-granted source always sees src_ready=0.

Optional Feature:
IDLE_FILL_EN
- Defined: in IDLE and GAP, drive pushout=1, startout=0, dataout=9'h1BC (K28.5 fill) every cycle.
- Undefined: pushout=0 and dataout=0 in those states.
- No other difference: arbitration, gap timing and the frame contents are identical either way.

Decomposition:
- Package enc_seq_pkg:
  - state enum: IDLE, SYNC, DATA, DRAIN, EOD, CRC, EOF, GAP.
  - symbol constants: K28_1=9'h13C, K23_7=9'h1F7, K28_5=9'h1BC.
  - CRC constants: polynomial, init value, final XOR value.
- One sub-module, crc32_d8: combinational next-CRC from (crc[31:0], byte[7:0]). It is instantiated once; the sequencer owns the CRC register.

Test Plan:
1. Source 0 sends bytes 31..39 ("123456789") with src_last on 39 -> contiguous symbols 13C(startout=1), 13C x3, 031..039, 1F7, 026, 039, 0F4, 0CB, 1BC; gnt=01 throughout.
2. Both req rise in the same cycle after reset -> source 0 frame first; K28.5, then exactly 2 pushout=0 cycles, then source 1 frame with startout=1.
3. src_valid[0] low for 3 cycles mid-payload -> 3 pushout=0 gaps; CRC bytes identical to scenario 1.
4. MAX_LEN=4, 6-byte frame -> 4 data symbols, len_err pulse, last 2 bytes accepted with no output, then 1F7 plus CRC over the 4 bytes, then 1BC.
5. reset pulsed during DATA -> outputs 0 in the same cycle; a later request produces a full frame whose CRC ignores pre-reset bytes.
6. IDLE_FILL_EN defined, no req -> pushout=1, dataout=1BC every cycle; on req, the next symbol is 13C with startout=1.

Source files
------------

// File: rtl/enc_seq_pkg.sv
// rtl/enc_seq_pkg.sv - states, symbol codes and CRC-32 constants for enc_frame_sequencer
package enc_seq_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SYNC  = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_EOD   = 3'd4;
  localparam logic [2:0] ST_CRC   = 3'd5;
  localparam logic [2:0] ST_EOF   = 3'd6;
  localparam logic [2:0] ST_GAP   = 3'd7;

  localparam logic [8:0] K28_1 = 9'h13C;
  localparam logic [8:0] K23_7 = 9'h1F7;
  localparam logic [8:0] K28_5 = 9'h1BC;

  localparam logic [31:0] CRC_POLY   = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_XOROUT = 32'hFFFFFFFF;

  // The LSB-first shift register needs the bit-reversed polynomial.
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// rtl/crc32_d8.sv - combinational reflected CRC-32 update for one byte
module crc32_d8 import enc_seq_pkg::*; (
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  always_comb begin
    logic [31:0] c;
    logic [31:0] poly_r;
    poly_r = reflect32(CRC_POLY);
    c = crc_i ^ {24'd0, data_i};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ poly_r) : (c >> 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/enc_frame_sequencer.sv
// rtl/enc_frame_sequencer.sv - two-source framer feeding the 8b/10b encoder
// Define IDLE_FILL_EN to send K28.5 fill symbols in IDLE and GAP.
module enc_frame_sequencer import enc_seq_pkg::*; #(
  parameter int SYNC_CNT = 4,
  parameter int MAX_LEN  = 1024,
  parameter int GAP_CYC  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  input  logic [1:0]  src_valid,
  input  logic [15:0] src_data,
  input  logic [1:0]  src_last,
  output logic [1:0]  src_ready,
  output logic        pushout,
  output logic        startout,
  output logic [8:0]  dataout,
  output logic        len_err
);

  localparam logic [7:0]  SYNC_C = 8'(SYNC_CNT);
  localparam logic [7:0]  GAP_C  = 8'(GAP_CYC);
  localparam logic [10:0] MAX_C  = 11'(MAX_LEN);

`ifdef IDLE_FILL_EN
  localparam logic       IDLE_PUSH = 1'b1;
  localparam logic [8:0] IDLE_SYM  = K28_5;
`else
  localparam logic       IDLE_PUSH = 1'b0;
  localparam logic [8:0] IDLE_SYM  = 9'h000;
`endif

  logic [2:0]  state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        ptr_q, ptr_d;
  logic [10:0] cnt_q, cnt_d;
  logic [7:0]  sub_q, sub_d;
  logic [31:0] crc_q, crc_d;
  logic        push_q, push_d;
  logic        start_q, start_d;
  logic [8:0]  data_q, data_d;
  logic        len_err_q, len_err_d;

  logic        grant_src;
  logic [7:0]  byte_w;
  logic        xfer;
  logic        last_w;
  logic [31:0] crc_nxt;
  logic [31:0] crc_out;

  assign src_ready = (state_q == ST_DATA || state_q == ST_DRAIN) ? gnt_q : 2'b00;
  assign byte_w    = gnt_q[1] ? src_data[15:8] : src_data[7:0];
  assign xfer      = |(src_valid & src_ready);
  assign last_w    = |(src_last & gnt_q);
  assign crc_out   = crc_q ^ CRC_XOROUT;
  // ptr_q=1 favours source 1; otherwise source 0 wins whenever it asks.
  assign grant_src = ptr_q ? req[1] : ~req[0];

  crc32_d8 u_crc (
    .crc_i  (crc_q),
    .data_i (byte_w),
    .crc_o  (crc_nxt)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    sub_d     = sub_q;
    crc_d     = crc_q;
    push_d    = 1'b0;
    start_d   = 1'b0;
    data_d    = 9'h000;
    len_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        push_d = IDLE_PUSH;
        data_d = IDLE_SYM;
        cnt_d  = 11'd0;
        sub_d  = 8'd0;
        if (|req) begin
          gnt_d   = grant_src ? 2'b10 : 2'b01;
          ptr_d   = ~grant_src;
          push_d  = 1'b1;
          start_d = 1'b1;
          data_d  = K28_1;
          sub_d   = 8'd1;
          state_d = (SYNC_C == 8'd1) ? ST_DATA : ST_SYNC;
        end
      end
      ST_SYNC: begin
        push_d = 1'b1;
        data_d = K28_1;
        sub_d  = sub_q + 8'd1;
        if (sub_q + 8'd1 == SYNC_C) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (xfer) begin
          push_d = 1'b1;
          data_d = {1'b0, byte_w};
          crc_d  = crc_nxt;
          cnt_d  = cnt_q + 11'd1;
          if (last_w) begin
            state_d = ST_EOD;
          end else if (cnt_q + 11'd1 == MAX_C) begin
            state_d   = ST_DRAIN;
            len_err_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (xfer && last_w) state_d = ST_EOD;
      end
      ST_EOD: begin
        push_d  = 1'b1;
        data_d  = K23_7;
        sub_d   = 8'd0;
        state_d = ST_CRC;
      end
      ST_CRC: begin
        push_d = 1'b1;
        data_d = {1'b0, crc_out[{sub_q[1:0], 3'b000} +: 8]};
        sub_d  = sub_q + 8'd1;
        if (sub_q[1:0] == 2'd3) state_d = ST_EOF;
      end
      ST_EOF: begin
        push_d  = 1'b1;
        data_d  = K28_5;
        gnt_d   = 2'b00;
        crc_d   = CRC_INIT;
        sub_d   = 8'd0;
        state_d = (GAP_C == 8'd0) ? ST_IDLE : ST_GAP;
      end
      ST_GAP: begin
        push_d = IDLE_PUSH;
        data_d = IDLE_SYM;
        sub_d  = sub_q + 8'd1;
        if (sub_q + 8'd1 == GAP_C) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 2'b00;
      ptr_q     <= 1'b0;
      cnt_q     <= 11'd0;
      sub_q     <= 8'd0;
      crc_q     <= CRC_INIT;
      push_q    <= 1'b0;
      start_q   <= 1'b0;
      data_q    <= 9'h000;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      sub_q     <= sub_d;
      crc_q     <= crc_d;
      push_q    <= push_d;
      start_q   <= start_d;
      data_q    <= data_d;
      len_err_q <= len_err_d;
    end
  end

  assign gnt      = gnt_q;
  assign pushout  = push_q;
  assign startout = start_q;
  assign dataout  = data_q;
  assign len_err  = len_err_q;

endmodule

// File: tb/tb_enc_frame_sequencer.sv
// tb/tb_enc_frame_sequencer.sv - scoreboard bench for enc_frame_sequencer, default or IDLE_FILL_EN build
module tb_enc_frame_sequencer;

`ifdef IDLE_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif
  localparam logic [10:0] IDLE_EXP = FILL ? {1'b1, 1'b0, 9'h1BC} : 11'd0;

  // entry: [12] follows previous frame back-to-back, [11:10] gnt, [9] startout, [8:0] symbol
  typedef logic [12:0] ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic [1:0]  req       [2];
  logic [1:0]  gnt       [2];
  logic [1:0]  src_valid [2];
  logic [15:0] src_data  [2];
  logic [1:0]  src_last  [2];
  logic [1:0]  src_ready [2];
  logic        pushout   [2];
  logic        startout  [2];
  logic [8:0]  dataout   [2];
  logic        len_err   [2];

  enc_frame_sequencer u_a (
    .clk(clk), .reset(rst[0]), .req(req[0]), .gnt(gnt[0]),
    .src_valid(src_valid[0]), .src_data(src_data[0]), .src_last(src_last[0]),
    .src_ready(src_ready[0]), .pushout(pushout[0]), .startout(startout[0]),
    .dataout(dataout[0]), .len_err(len_err[0])
  );

  enc_frame_sequencer #(.SYNC_CNT(1), .MAX_LEN(4), .GAP_CYC(0)) u_b (
    .clk(clk), .reset(rst[1]), .req(req[1]), .gnt(gnt[1]),
    .src_valid(src_valid[1]), .src_data(src_data[1]), .src_last(src_last[1]),
    .src_ready(src_ready[1]), .pushout(pushout[1]), .startout(startout[1]),
    .dataout(dataout[1]), .len_err(len_err[1])
  );

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  ent_t expq [2][$];
  int   eof_cyc [2] = '{0, 0};
  bit   have_eof [2] = '{1'b0, 1'b0};
  int   len_err_cnt [2] = '{0, 0};

  logic [7:0] d9[$], sa[$], sb[$], sc[$], sd[$], f4[$], e6[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int gap_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic logic [31:0] crc32_ref(input logic [7:0] b[$], input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, b[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic void push_frame(input int k, input int src, input logic [7:0] b[$],
                                     input int sync_n, input int maxlen,
                                     input logic [31:0] crc, input bit b2b);
    logic [1:0] g;
    g = (src == 1) ? 2'b10 : 2'b01;
    expq[k].push_back({b2b, g, 1'b1, 9'h13C});
    for (int i = 1; i < sync_n; i++) expq[k].push_back({1'b0, g, 1'b0, 9'h13C});
    for (int i = 0; i < b.size() && i < maxlen; i++) expq[k].push_back({1'b0, g, 1'b0, 1'b0, b[i]});
    expq[k].push_back({1'b0, g, 1'b0, 9'h1F7});
    for (int i = 0; i < 4; i++) expq[k].push_back({1'b0, g, 1'b0, 1'b0, crc[8*i +: 8]});
    expq[k].push_back({1'b0, 2'b00, 1'b0, 9'h1BC});
  endfunction

  always @(negedge clk) begin
    ent_t e;
    for (int k = 0; k < 2; k++) begin
      if (len_err[k]) len_err_cnt[k]++;
      if (gnt[k] != 2'b00) begin
        checks++;
        if ((src_ready[k] & ~gnt[k]) != 2'b00) begin
          failures++;
          $display("FAIL ready_mask inst=%0d src_ready=%b gnt=%b", k, src_ready[k], gnt[k]);
        end
      end
      if (pushout[k] && !(FILL && dataout[k] == 9'h1BC && gnt[k] == 2'b00 &&
          (expq[k].size() == 0 || expq[k][0][8:0] != 9'h1BC))) begin
        checks++;
        if (expq[k].size() == 0) begin
          failures++;
          $display("FAIL unexpected_sym inst=%0d got=%h start=%b required=none", k, dataout[k], startout[k]);
        end else begin
          e = expq[k].pop_front();
          if ({gnt[k], startout[k], dataout[k]} != e[11:0]) begin
            failures++;
            $display("FAIL sym inst=%0d got gnt=%b start=%b data=%h required gnt=%b start=%b data=%h",
                     k, gnt[k], startout[k], dataout[k], e[11:10], e[9], e[8:0]);
          end
          if (e[12]) begin
            checks++;
            if (!have_eof[k] || (cyc - eof_cyc[k]) != gap_of(k) + 1) begin
              failures++;
              $display("FAIL gap inst=%0d got=%0d required=%0d", k, cyc - eof_cyc[k], gap_of(k) + 1);
            end
          end
          if (e[8:0] == 9'h1BC) begin
            have_eof[k] = 1'b1;
            eof_cyc[k]  = cyc;
          end
        end
      end
    end
  end

  task automatic chk_zero(input int k, input string name);
    checks++;
    if ({gnt[k], src_ready[k], pushout[k], startout[k], dataout[k], len_err[k]} != 16'd0) begin
      failures++;
      $display("FAIL %s inst=%0d got gnt=%b rdy=%b push=%b start=%b data=%h lerr=%b required all zero",
               name, k, gnt[k], src_ready[k], pushout[k], startout[k], dataout[k], len_err[k]);
    end
  endtask

  task automatic send(input int k, input int src, input logic [7:0] b[$], input int bub_at, input int bub_n);
    int tmo;
    @(negedge clk);
    req[k][src] = 1'b1;
    for (int i = 0; i < b.size(); i++) begin
      if (i == bub_at) begin
        src_valid[k][src] = 1'b0;
        repeat (bub_n) @(negedge clk);
      end
      src_valid[k][src] = 1'b1;
      src_data[k][8*src +: 8] = b[i];
      src_last[k][src] = (i == b.size() - 1);
      tmo = 0;
      while (!src_ready[k][src] && tmo < 3000) begin
        @(negedge clk);
        tmo++;
      end
      if (tmo >= 3000) begin
        checks++;
        failures++;
        $display("FAIL ready_timeout inst=%0d src=%0d byte=%0d got=no_ready required=ready", k, src, i);
        break;
      end
      @(negedge clk);
    end
    src_valid[k][src] = 1'b0;
    src_last[k][src]  = 1'b0;
    req[k][src]       = 1'b0;
  endtask

  task automatic wait_drain(input int k);
    int tmo;
    tmo = 0;
    while (expq[k].size() != 0 && tmo < 5000) begin
      @(negedge clk);
      tmo++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (expq[k].size() != 0) begin
      failures++;
      $display("FAIL drain inst=%0d got_pending=%0d required=0", k, expq[k].size());
    end
  endtask

  initial begin
    int tmo;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      req[k] = 2'b00;
      src_valid[k] = 2'b00;
      src_data[k] = 16'h0000;
      src_last[k] = 2'b00;
    end
    d9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    sa = '{8'hA0, 8'hA1, 8'hA2};
    sb = '{8'hB0, 8'hB1};
    sc = '{8'hC0};
    sd = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
    f4 = '{8'h11, 8'h12, 8'h13, 8'h14};
    e6 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};

    repeat (2) @(negedge clk);
    chk_zero(0, "reset_a");
    chk_zero(1, "reset_b");
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({pushout[0], startout[0], dataout[0]} != IDLE_EXP) begin
        failures++;
        $display("FAIL idle_out got=%h required=%h", {pushout[0], startout[0], dataout[0]}, IDLE_EXP);
      end
    end

    // both request together after reset: source 0 first, then source 1 after the gap
    push_frame(0, 0, sa, 4, 1024, crc32_ref(sa, 3), 1'b0);
    push_frame(0, 1, sb, 4, 1024, crc32_ref(sb, 2), 1'b1);
    fork
      send(0, 0, sa, -1, 0);
      send(0, 1, sb, -1, 0);
    join

    push_frame(0, 0, d9, 4, 1024, 32'hCBF43926, 1'b0);
    send(0, 0, d9, -1, 0);

    push_frame(0, 0, d9, 4, 1024, 32'hCBF43926, 1'b0);
    send(0, 0, d9, 4, 3);

    // pointer now favours source 1
    push_frame(0, 1, sc, 4, 1024, crc32_ref(sc, 1), 1'b0);
    push_frame(0, 0, sd, 4, 1024, crc32_ref(sd, 4), 1'b1);
    fork
      send(0, 0, sd, -1, 0);
      send(0, 1, sc, -1, 0);
    join
    wait_drain(0);

    // reset in the middle of a payload
    expq[0].push_back({1'b0, 2'b01, 1'b1, 9'h13C});
    for (int i = 0; i < 3; i++) expq[0].push_back({1'b0, 2'b01, 1'b0, 9'h13C});
    expq[0].push_back({1'b0, 2'b01, 1'b0, 9'h0AA});
    @(negedge clk);
    req[0][0] = 1'b1;
    src_valid[0][0] = 1'b1;
    src_data[0][7:0] = 8'hAA;
    tmo = 0;
    while (!src_ready[0][0] && tmo < 100) begin
      @(negedge clk);
      tmo++;
    end
    @(posedge clk);
    @(negedge clk);
    src_data[0][7:0] = 8'hBB;
    @(posedge clk);
    #2 rst[0] = 1'b1;
    #1 chk_zero(0, "reset_mid");
    @(negedge clk);
    req[0] = 2'b00;
    src_valid[0] = 2'b00;
    @(negedge clk);
    rst[0] = 1'b0;
    checks++;
    if (expq[0].size() != 0) begin
      failures++;
      $display("FAIL pre_reset_syms got_pending=%0d required=0", expq[0].size());
    end
    expq[0].delete();

    push_frame(0, 0, d9, 4, 1024, 32'hCBF43926, 1'b0);
    send(0, 0, d9, -1, 0);
    wait_drain(0);

    // MAX_LEN=4 instance: exact-length frame, then a truncated one
    push_frame(1, 0, f4, 1, 4, crc32_ref(f4, 4), 1'b0);
    push_frame(1, 1, e6, 1, 4, crc32_ref(e6, 4), 1'b1);
    fork
      send(1, 0, f4, -1, 0);
      send(1, 1, e6, -1, 0);
    join
    wait_drain(1);

    checks++;
    if (len_err_cnt[0] != 0) begin
      failures++;
      $display("FAIL len_err_a got=%0d required=0", len_err_cnt[0]);
    end
    checks++;
    if (len_err_cnt[1] != 1) begin
      failures++;
      $display("FAIL len_err_b got=%0d required=1", len_err_cnt[1]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
